// File: rtl/cannon_pkg.sv
// rtl/cannon_pkg.sv - shared defaults, FSM states and flat-packing helpers for the Cannon host interface
package cannon_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;
  localparam int RW_DEF = 8;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    START     = 3'd1,
    WAIT_DROP = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } state_e;

  // Row-major element index of (i,j) in an n x n matrix.
  function automatic int elem_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

  function automatic int elem_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/cannon_result_drain.sv
// rtl/cannon_result_drain.sv - result buffer and row-major output stream for the Cannon host interface
module cannon_result_drain
  import cannon_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int RW = RW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            capture,
  input  logic [N*N*RW-1:0] mat_s,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [RW-1:0]   out_data,
  output logic            out_last,
  output logic            drain_last
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;

  logic [NE*RW-1:0] res_q, res_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;

  always_comb begin
    res_d   = res_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (capture) begin
      res_d   = mat_s;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      if (idx_q == IW'(NE - 1)) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Data and last depend only on registered state, so they hold while stalled.
  assign out_valid  = valid_q;
  assign out_data   = res_q[elem_lsb(int'(idx_q), RW) +: RW];
  assign out_last   = valid_q && (idx_q == IW'(NE - 1));
  assign drain_last = out_last && out_ready;

endmodule

// File: rtl/cannon_host_if.sv
// rtl/cannon_host_if.sv - host stream front/back end that loads, starts and drains the Cannon array
module cannon_host_if
  import cannon_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RW-1:0]     out_data,
  output logic              out_last,
  output logic [N*N*DW-1:0] mat_a,
  output logic [N*N*DW-1:0] mat_b,
  output logic              arr_start,
  input  logic              arr_done,
  input  logic [N*N*RW-1:0] mat_s,
  output logic              busy,
  output logic              err
);

  localparam int NE = N * N;
  localparam int KW = $clog2(2 * NE);
  localparam int TW = $clog2(TIMEOUT);

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic [NE*DW-1:0] mat_a_q, mat_a_d;
  logic [NE*DW-1:0] mat_b_q, mat_b_d;
  logic             capture;
  logic             drain_last;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tcnt_d  = tcnt_q;
    err_d   = err_q;
    mat_a_d = mat_a_q;
    mat_b_d = mat_b_q;
    capture = 1'b0;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          if (k_q < KW'(NE)) begin
            mat_a_d[elem_lsb(int'(k_q), DW) +: DW] = in_data;
          end else begin
            mat_b_d[elem_lsb(int'(k_q) - NE, DW) +: DW] = in_data;
          end
          if (k_q == KW'(2 * NE - 1)) begin
            state_d = START;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      START: begin
        state_d = WAIT_DROP;
        tcnt_d  = '0;
      end
      // The exit condition wins over the timeout on the same cycle.
      WAIT_DROP, WAIT_DONE: begin
        if ((state_q == WAIT_DROP) && !arr_done) begin
          state_d = WAIT_DONE;
          tcnt_d  = '0;
        end else if ((state_q == WAIT_DONE) && arr_done) begin
          capture = 1'b1;
          state_d = DRAIN;
        end else if (tcnt_q == TW'(TIMEOUT - 2)) begin
          err_d   = 1'b1;
          state_d = FILL;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      k_q     <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      mat_a_q <= '0;
      mat_b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
    end
  end

  cannon_result_drain #(.N(N), .RW(RW)) u_drain (
    .clk        (clk),
    .rst        (rst),
    .capture    (capture),
    .mat_s      (mat_s),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .drain_last (drain_last)
  );

  assign in_ready  = (state_q == FILL);
  assign arr_start = (state_q == START);
  assign busy      = (state_q != FILL);
  assign err       = err_q;
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;

endmodule

// File: tb/tb_cannon_host_if.sv
// tb/tb_cannon_host_if.sv - directed self-checking bench for cannon_host_if with a behavioural array stub
module tb_cannon_host_if;
  import cannon_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_data;
  logic         out_last;
  logic [127:0] mat_a, mat_b, mat_s;
  logic         arr_start;
  logic         arr_done;
  logic         busy;
  logic         err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cannon_host_if #(.N(4), .DW(8), .RW(8), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .arr_start (arr_start),
    .arr_done  (arr_done),
    .mat_s     (mat_s),
    .busy      (busy),
    .err       (err)
  );

  // Array stub: mode 0 normal (done 6 cycles after start), 1 stale done, 2 done stuck low.
  int           mode = 0;
  int           t = 0;
  int           ts = 0;
  bit           active = 1'b0;
  logic         done_r = 1'b0;
  logic [127:0] s_r = {16{8'hEE}};

  function automatic logic [127:0] prod(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] s;
    logic [7:0]   acc;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc + 8'(a[elem_idx(i, k, 4)*8 +: 8] * b[elem_idx(k, j, 4)*8 +: 8]);
        s[elem_idx(i, j, 4)*8 +: 8] = acc;
      end
    end
    return s;
  endfunction

  always @(posedge clk) begin
    t <= t + 1;
    if (rst) begin
      active <= 1'b0;
      done_r <= 1'b0;
    end else if (arr_start) begin
      ts     <= t;
      active <= 1'b1;
      done_r <= (mode == 1);
      s_r    <= {16{8'hEE}};
    end else if (active) begin
      // Product is presented only on the rise cycle, so a late capture sees garbage.
      done_r <= (mode != 2) && (t - ts >= ((mode == 1) ? 6 : 5));
      s_r    <= ((mode != 2) && (t - ts == ((mode == 1) ? 6 : 5))) ? prod(mat_a, mat_b) : {16{8'hEE}};
    end
  end

  assign arr_done = done_r;
  assign mat_s    = s_r;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_wait", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [7:0] a [16], input logic [7:0] b [16], input int maxgap);
    logic [127:0] pa, pb;
    for (int k = 0; k < 32; k++) begin
      chk("arr_start_pre", arr_start, 0);
      send((k < 16) ? a[k] : b[k - 16], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    for (int k = 0; k < 16; k++) begin
      pa[k*8 +: 8] = a[k];
      pb[k*8 +: 8] = b[k];
    end
    chk("arr_start_pulse", arr_start, 1);
    chk("in_ready_start", in_ready, 0);
    chk("busy_start", busy, 1);
    chk("mat_a_pack", mat_a, pa);
    chk("mat_b_pack", mat_b, pb);
    @(negedge clk);
    chk("arr_start_width", arr_start, 0);
  endtask

  task automatic recv(input logic [7:0] e [16], input int n, input int pat);
    int got = 0;
    int c = 0;
    int guard = 0;
    while (got < n && guard < 400) begin
      @(negedge clk);
      guard++;
      out_ready = (pat == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (out_valid) begin
        c++;
        chk("out_data", out_data, e[got]);
        chk("out_last", out_last, (got == 15));
        chk("in_ready_drain", in_ready, 0);
        if (out_ready) got++;
      end
    end
    if (guard >= 400) chk("recv_timeout", got, n);
  endtask

  task automatic drain_end();
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_end", out_valid, 0);
    chk("in_ready_end", in_ready, 1);
  endtask

  logic [7:0] ident [16];
  logic [7:0] ramp  [16];
  logic [7:0] two_i [16];
  logic [7:0] threes[16];
  logic [7:0] sixes [16];

  initial begin
    for (int k = 0; k < 16; k++) begin
      ident[k]  = (k / 4 == k % 4) ? 8'd1 : 8'd0;
      two_i[k]  = (k / 4 == k % 4) ? 8'd2 : 8'd0;
      ramp[k]   = 8'(k + 1);
      threes[k] = 8'd3;
      sixes[k]  = 8'd6;
    end

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_arr_start", arr_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_mat_a", mat_a, 0);
    chk("rst_mat_b", mat_b, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    mode = 0;
    load(ident, ramp, 0);
    recv(ramp, 16, 0);
    drain_end();

    load(ident, ramp, 0);
    recv(ramp, 16, 1);
    drain_end();

    mode = 1;
    load(two_i, threes, 0);
    recv(sixes, 16, 0);
    drain_end();

    mode = 2;
    load(ident, ramp, 0);
    repeat (7) @(negedge clk);
    chk("err_early", err, 0);
    @(negedge clk);
    chk("err_timeout", err, 1);
    chk("timeout_in_ready", in_ready, 1);
    chk("timeout_out_valid", out_valid, 0);

    mode = 0;
    load(ident, ramp, 0);
    recv(ramp, 16, 0);
    drain_end();
    chk("err_sticky", err, 1);

    load(ident, ramp, 0);
    recv(ramp, 5, 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_mat_a", mat_a, 0);
    chk("rst_mid_err", err, 0);
    load(ident, ramp, 0);
    recv(ramp, 16, 0);
    drain_end();

    load(two_i, threes, 3);
    recv(sixes, 16, 0);
    drain_end();
    load(two_i, threes, 3);
    recv(sixes, 16, 0);
    drain_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
